// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared byte-lane data memory.
// Optional transfer statistics are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rstd,
`ifdef DMEM_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   xfer_cnt_a,
    output logic [15:0]   xfer_cnt_b,
`endif
    input  logic          req_a,
    input  logic          lock_a,
    input  logic [AW-1:0] addr_a,
    input  logic [31:0]   wdata_a,
    input  logic [3:0]    wren_n_a,
    output logic          gnt_a,
    input  logic          req_b,
    input  logic          lock_b,
    input  logic [AW-1:0] addr_b,
    input  logic [31:0]   wdata_b,
    input  logic [3:0]    wren_n_b,
    output logic          gnt_b,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_wren_n,
    input  logic [31:0]   m_rdata,
    output logic [31:0]   rdata
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_last_a;
    logic [3:0] r_hold_cnt;
    logic [3:0] w_hold_nxt;
    logic       r_gnt_a;
    logic       r_gnt_b;
    logic       w_xfer_a;
    logic       w_xfer_b;

    // A locked owner yields only once the hold limit is reached
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b)
                    w_next = r_last_a ? OWN_B : OWN_A;
                else if (req_a)
                    w_next = OWN_A;
                else if (req_b)
                    w_next = OWN_B;
            end
            OWN_A: begin
                if (!req_a)
                    w_next = req_b ? OWN_B : IDLE;
                else if (req_b && (!lock_a || r_hold_cnt >= HOLD_LIM))
                    w_next = OWN_B;
            end
            OWN_B: begin
                if (!req_b)
                    w_next = req_a ? OWN_A : IDLE;
                else if (req_a && (!lock_b || r_hold_cnt >= HOLD_LIM))
                    w_next = OWN_A;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_hold_nxt = r_hold_cnt;
        if (w_next != r_state)
            w_hold_nxt = 4'd0;
        else if (r_hold_cnt < HOLD_LIM &&
                 ((r_state == OWN_A && req_b) || (r_state == OWN_B && req_a)))
            w_hold_nxt = r_hold_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state    <= IDLE;
            r_last_a   <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= w_hold_nxt;
            r_gnt_a    <= (w_next == OWN_A);
            r_gnt_b    <= (w_next == OWN_B);
            if (w_next == OWN_A && r_state != OWN_A)
                r_last_a <= 1'b1;
            else if (w_next == OWN_B && r_state != OWN_B)
                r_last_a <= 1'b0;
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign w_xfer_a = req_a && r_gnt_a;
    assign w_xfer_b = req_b && r_gnt_b;

    // Memory sees idle values unless the owner is actively requesting
    always_comb begin
        m_addr   = '0;
        m_wdata  = '0;
        m_wren_n = 4'hF;
        if (w_xfer_a) begin
            m_addr   = addr_a;
            m_wdata  = wdata_a;
            m_wren_n = wren_n_a;
        end else if (w_xfer_b) begin
            m_addr   = addr_b;
            m_wdata  = wdata_b;
            m_wren_n = wren_n_b;
        end
    end

    assign rdata = m_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_cnt_a <= 16'd0;
            r_cnt_b <= 16'd0;
        end else if (stats_clr) begin
            r_cnt_a <= 16'd0;
            r_cnt_b <= 16'd0;
        end else begin
            if (w_xfer_a && r_cnt_a != 16'hFFFF)
                r_cnt_a <= r_cnt_a + 16'd1;
            if (w_xfer_b && r_cnt_b != 16'hFFFF)
                r_cnt_b <= r_cnt_b + 16'd1;
        end
    end

    assign xfer_cnt_a = r_cnt_a;
    assign xfer_cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural byte-lane memory.
// Stats checks run only when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rstd;
    logic        req_a, lock_a, req_b, lock_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [3:0]  wren_n_a, wren_n_b;
    logic        gnt_a, gnt_b;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata, rdata;
    logic [3:0]  m_wren_n;
`ifdef DMEM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] xfer_cnt_a, xfer_cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    dmem_arbiter #(.AW(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rstd(rstd),
`ifdef DMEM_ARB_STATS_EN
        .stats_clr(stats_clr), .xfer_cnt_a(xfer_cnt_a), .xfer_cnt_b(xfer_cnt_b),
`endif
        .req_a(req_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .wren_n_a(wren_n_a), .gnt_a(gnt_a),
        .req_b(req_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .wren_n_b(wren_n_b), .gnt_b(gnt_b),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wren_n(m_wren_n),
        .m_rdata(m_rdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!m_wren_n[i]) mem[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; lock_a = 0; addr_a = 0; wdata_a = 0; wren_n_a = 4'hF;
        req_b = 0; lock_b = 0; addr_b = 0; wdata_b = 0; wren_n_b = 4'hF;
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rstd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstd = 1'b1;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [31:0] d);
        req_a = 1; addr_a = a; wdata_a = d; wren_n_a = 4'h0;
        tick();
        tick();
        req_a = 0; wren_n_a = 4'hF;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        req_a = 1; req_b = 1; wren_n_a = 4'h0; wren_n_b = 4'h0; addr_a = 8'h55;
        rstd = 1'b0;
        #1;
        checks++;
        if ({gnt_a, gnt_b, m_wren_n, m_addr} !== {2'b00, 4'hF, 8'h00}) begin
            failures++;
            $display("FAIL reset_async: gnt=%b wren_n=%h addr=%h, need gnt=00 wren_n=f addr=00",
                     {gnt_a, gnt_b}, m_wren_n, m_addr);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, m_wren_n, m_wdata} !== {2'b00, 4'hF, 32'h0}) begin
            failures++;
            $display("FAIL reset_hold: gnt=%b wren_n=%h wdata=%h, need gnt=00 wren_n=f wdata=0",
                     {gnt_a, gnt_b}, m_wren_n, m_wdata);
        end
        do_reset();
    endtask

    task automatic test_port_a_write_read();
        do_reset();
        req_a = 1; addr_a = 8'h10; wren_n_a = 4'h0; wdata_a = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, m_wren_n} !== {2'b00, 4'hF}) begin
            failures++;
            $display("FAIL a_idle_cycle: gnt=%b wren_n=%h, need 00 f", {gnt_a, gnt_b}, m_wren_n);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gnt_a, m_wren_n, m_addr, m_wdata} !== {1'b1, 4'h0, 8'h10, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL a_write: gnt_a=%b wren_n=%h addr=%h wdata=%h, need 1 0 10 deadbeef",
                     gnt_a, m_wren_n, m_addr, m_wdata);
        end
        tick();
        wren_n_a = 4'hF;
        @(negedge clk);
        checks++;
        if ({rdata, m_wren_n} !== {32'hDEADBEEF, 4'hF}) begin
            failures++;
            $display("FAIL a_readback: rdata=%h wren_n=%h, need deadbeef f", rdata, m_wren_n);
        end
        tick();
        req_a = 0; wren_n_a = 4'h0;
        @(negedge clk);
        checks++;
        if ({gnt_a, m_wren_n, m_addr} !== {1'b1, 4'hF, 8'h00}) begin
            failures++;
            $display("FAIL a_dropped_req: gnt_a=%b wren_n=%h addr=%h, need 1 f 00",
                     gnt_a, m_wren_n, m_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            failures++;
            $display("FAIL a_release: gnt=%b, need 00", {gnt_a, gnt_b});
        end
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        logic [3:0] ew;
        do_reset();
        req_a = 1; addr_a = 8'h40; wren_n_a = 4'hE; wdata_a = 32'h01010101;
        req_b = 1; addr_b = 8'h41; wren_n_b = 4'hC; wdata_b = 32'h02020202;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            failures++;
            $display("FAIL alt_idle: gnt=%b, need 00", {gnt_a, gnt_b});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            ew = (i % 2 == 0) ? 4'hE : 4'hC;
            checks++;
            if ({gnt_a, gnt_b, m_wren_n} !== {eg, ew}) begin
                failures++;
                $display("FAIL alt_cycle%0d: gnt=%b wren_n=%h, need %b %h",
                         i, {gnt_a, gnt_b}, m_wren_n, eg, ew);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_hold();
        logic [1:0] exp_g [0:5];
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset();
        req_a = 1; lock_a = 1; req_b = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({gnt_a, gnt_b} !== exp_g[i]) begin
                failures++;
                $display("FAIL lock_cycle%0d: gnt=%b, need %b", i, {gnt_a, gnt_b}, exp_g[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_port_b_byte();
        do_reset();
        wr_a(8'h20, 32'h11223344);
        req_b = 1; addr_b = 8'h20; wren_n_b = 4'hE; wdata_b = 32'h000000AA;
        req_a = 0; addr_a = 8'h20; wren_n_a = 4'h0; wdata_a = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, m_wren_n} !== {2'b00, 4'hF}) begin
            failures++;
            $display("FAIL b_idle_cycle: gnt=%b wren_n=%h, need 00 f", {gnt_a, gnt_b}, m_wren_n);
        end
        tick();
        req_a = 1;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, m_wren_n, m_addr, m_wdata} !== {2'b01, 4'hE, 8'h20, 32'h000000AA}) begin
            failures++;
            $display("FAIL b_byte_write: gnt=%b wren_n=%h addr=%h wdata=%h, need 01 e 20 000000aa",
                     {gnt_a, gnt_b}, m_wren_n, m_addr, m_wdata);
        end
        tick();
        req_a = 0; wren_n_b = 4'hF;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, m_wren_n, m_addr} !== {2'b10, 4'hF, 8'h00}) begin
            failures++;
            $display("FAIL b_owner_no_req: gnt=%b wren_n=%h addr=%h, need 10 f 00",
                     {gnt_a, gnt_b}, m_wren_n, m_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gnt_b, rdata} !== {1'b1, 32'h112233AA}) begin
            failures++;
            $display("FAIL b_readback: gnt_b=%b rdata=%h, need 1 112233aa", gnt_b, rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        wr_a(8'h30, 32'hCAFEF00D);
        req_b = 1; addr_b = 8'h30; wren_n_b = 4'h0; wdata_b = 32'h0;
        tick();
        @(negedge clk);
        checks++;
        if ({gnt_b, m_wren_n} !== {1'b1, 4'h0}) begin
            failures++;
            $display("FAIL rst_pending_write: gnt_b=%b wren_n=%h, need 1 0", gnt_b, m_wren_n);
        end
        #1 rstd = 1'b0;
        #1;
        checks++;
        if ({gnt_b, m_wren_n} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL rst_abort: gnt_b=%b wren_n=%h, need 0 f", gnt_b, m_wren_n);
        end
        tick();
        tick();
        req_b = 0; wren_n_b = 4'hF;
        rstd = 1'b1;
        req_a = 1; addr_a = 8'h30; wren_n_a = 4'hF;
        tick();
        @(negedge clk);
        checks++;
        if ({gnt_a, rdata} !== {1'b1, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL rst_word_intact: gnt_a=%b rdata=%h, need 1 cafef00d", gnt_a, rdata);
        end
        idle_inputs();
        tick();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req_a = 1;
        tick();
        repeat (5) tick();
        req_a = 0; req_b = 1;
        tick();
        repeat (3) tick();
        req_b = 0;
        @(negedge clk);
        checks++;
        if ({xfer_cnt_a, xfer_cnt_b} !== {16'd5, 16'd3}) begin
            failures++;
            $display("FAIL stats_count: a=%0d b=%0d, need 5 3", xfer_cnt_a, xfer_cnt_b);
        end
        stats_clr = 1;
        tick();
        stats_clr = 0;
        @(negedge clk);
        checks++;
        if ({xfer_cnt_a, xfer_cnt_b} !== 32'h0) begin
            failures++;
            $display("FAIL stats_clear: a=%0d b=%0d, need 0 0", xfer_cnt_a, xfer_cnt_b);
        end
        req_a = 1;
        tick();
        tick();
        stats_clr = 1;
        tick();
        stats_clr = 0; req_a = 0;
        @(negedge clk);
        checks++;
        if (xfer_cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL stats_clr_priority: a=%0d, need 0", xfer_cnt_a);
        end
        req_a = 1;
        repeat (65540) tick();
        @(negedge clk);
        checks++;
        if ({xfer_cnt_a, xfer_cnt_b} !== {16'hFFFF, 16'h0}) begin
            failures++;
            $display("FAIL stats_saturate: a=%h b=%h, need ffff 0000", xfer_cnt_a, xfer_cnt_b);
        end
        tick();
        @(negedge clk);
        checks++;
        if (xfer_cnt_a !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate_hold: a=%h, need ffff", xfer_cnt_a);
        end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        idle_inputs();
        rstd = 1'b0;
        test_reset();
        test_port_a_write_read();
        test_alternate();
        test_lock_hold();
        test_port_b_byte();
        test_reset_mid_burst();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single byte-lane data memory between two requesters:
  - Port A: the processor load/store path.
  - Port B: a loader/debug/DMA master.
- Registered owner state machine with round-robin fairness, an optional lock that holds ownership for bursts, and a hold limit that prevents starvation.
- Sits between the requesters and the four 8-bit data-memory lanes. It drives the word address, the write data and the active-low per-lane write enables; read data from the memory is fanned back to both ports.

Parameters:
AW, 8, word-address width (256 words)
MAX_HOLD, 4, max consecutive cycles an owner keeps the memory while the other port requests; legal range 1..15

Ports:
clk  in  1  clock
rstd  in  1  reset, asynchronous, active-low
req_a  in  1  port A request
lock_a  in  1  port A asks to keep ownership (burst)
addr_a  in  AW  port A word address
wdata_a  in  32  port A write data
wren_n_a  in  4  port A lane write enables, active-low (1111 = read, 0000 = word, 1100 = half, 1110 = byte)
gnt_a  out  1  port A owns the memory this cycle
req_b, lock_b, addr_b, wdata_b, wren_n_b, gnt_b  same as port A, for port B
m_addr  out  AW  memory word address
m_wdata  out  32  memory write data, lane i = bits [8i+7:8i]
m_wren_n  out  4  memory lane write enables, active-low
m_rdata  in  32  memory read data (combinational read)
rdata  out  32  equals m_rdata, shared by both ports

Behaviour:
- States: IDLE, OWN_A, OWN_B. gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B. Both are registered outputs.
- Transfer rule: a transfer occurs on a cycle where req_x && gnt_x. In that cycle:
  - m_addr, m_wdata and m_wren_n = port x inputs.
  - Write commits at that posedge; read data is valid on rdata in the same cycle.
- Outputs with no transfer:
  - In IDLE, or when the owner's req is low: m_wren_n=1111, m_addr=0, m_wdata=0.
  - A non-owner's wren_n never reaches memory.
- Latency: request raised in IDLE gets its grant on the next cycle (1-cycle arbitration latency).
- last_owner register: updated on every entry to OWN_A/OWN_B; reset value B, so A wins the first tie.
- hold_cnt: 4-bit counter.
  - Cleared on every state change.
  - In OWN_x, increments each cycle the other port's req is high; saturates at MAX_HOLD-1.
- IDLE transitions:
  - req_a&req_b: go to the owner opposite last_owner.
  - Only one request: go to that port.
  - No request: stay in IDLE.
- OWN_x transitions (y = the other port):
  - !req_x && req_y: go to OWN_y.
  - !req_x && !req_y: go to IDLE.
  - req_x && !req_y: stay.
  - req_x && req_y && !lock_x: go to OWN_y (alternate every transfer).
  - req_x && req_y && lock_x: stay while hold_cnt < MAX_HOLD-1; at hold_cnt == MAX_HOLD-1, forced go to OWN_y.
- A port that drops req while owning loses the grant on the next cycle. Its dropped cycle produces no write.
- Reset: rstd low immediately forces IDLE, gnt_a=gnt_b=0, m_wren_n=1111, last_owner=B, hold_cnt=0.
  - Reset asserted mid-burst aborts the burst; there is no partial-write hazard beyond the current clock edge.
- No combinational path from req to gnt. The data path is combinational from the owner's inputs to the m_* outputs.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds input stats_clr (1 bit) and outputs xfer_cnt_a and xfer_cnt_b (16 bits each).
  - Each counter counts completed transfers of its port and saturates at 16'hFFFF.
  - stats_clr=1 synchronously zeroes both counters; clear takes precedence over a same-cycle increment.
  - Asynchronous reset zeroes both counters.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req_a=1 only, addr_a=8'h10, wren_n_a=0000, wdata_a=32'hDEADBEEF → gnt_a=1 the next cycle. Word 0x10 is written; a later read of 0x10 returns DEADBEEF.
- req_a=req_b=1 from IDLE just after reset, no locks → grants alternate A, B, A, B on consecutive cycles; m_wren_n always equals the current owner's wren_n.
- lock_a=1, req_a=req_b=1 held, MAX_HOLD=4 → gnt_a for exactly 4 consecutive cycles, then gnt_b=1.
- Port B owns with wren_n_b=1110, wdata_b=32'h000000AA to addr 0x20, which held 32'h11223344 → read returns 32'h112233AA. During the write, port A's wren_n_a=0000 has no effect.
- rstd pulled low during OWN_B with a write pending → gnt_b=0 and m_wren_n=1111 immediately; the target word is unchanged after reset releases.
- With DMEM_ARB_STATS_EN defined: 5 A transfers and 3 B transfers → xfer_cnt_a=5, xfer_cnt_b=3. Pulse stats_clr → both counters 0. Preload at FFFF plus one more transfer → stays FFFF.
